adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that lends one shared, externally
// pipelined adder to N_REQ requesters, one transaction at a time.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req                   per-requester request level
//   req_op1, req_op2      packed operands, slice i belongs to requester i
//   grant                 one-hot owner of the adder (zero when idle)
//   done                  one-hot, one-cycle completion pulse
//   result                sum for the requester flagged by done (held)
//   busy                  high whenever a transaction is in flight
//   add_enable            one-cycle enable to the shared adder
//   add_op1, add_op2      latched operands to the adder
//   add_result            adder sum, valid ADD_LATENCY cycles after enable
//
// Transaction shape: accept (IDLE), ISSUE, WAIT x ADD_LATENCY, DONE.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module adder_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ADD_LATENCY = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*`DATA_WIDTH-1:0]  req_op1,
  input  logic [N_REQ*`DATA_WIDTH-1:0]  req_op2,
  output logic [N_REQ-1:0]              grant,
  output logic [N_REQ-1:0]              done,
  output logic [`DATA_WIDTH-1:0]        result,
  output logic                          busy,
  output logic                          add_enable,
  output logic [`DATA_WIDTH-1:0]        add_op1,
  output logic [`DATA_WIDTH-1:0]        add_op2,
  input  logic [`DATA_WIDTH-1:0]        add_result
);

  localparam int unsigned W  = `DATA_WIDTH;
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_served, last_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   pick;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    op1_d, op2_d;
  logic [W-1:0]    result_d;
  logic [N_REQ-1:0] onehot_d;
  logic [N_REQ-1:0] grant_d, done_d;
  logic            busy_d, enable_d;
  int              idx;

  logic [W-1:0] op1_arr [N_REQ];
  logic [W-1:0] op2_arr [N_REQ];

  // Unpack the per-requester operand slices.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      op1_arr[i] = req_op1[i*W +: W];
      op2_arr[i] = req_op2[i*W +: W];
    end
  end

  // Round-robin pick: scan from farthest to nearest so the requester right
  // after last_served is written last and therefore wins.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      idx = (int'(last_served) + k) % int'(N_REQ);
      if (req[IW'(idx)]) pick = IW'(idx);
    end
  end

  // Next-state logic; outputs are derived from the next state so they can
  // be registered and still line up with the state they describe.
  always_comb begin
    state_d  = state_q;
    last_d   = last_served;
    win_d    = win_q;
    cnt_d    = cnt_q;
    op1_d    = add_op1;
    op2_d    = add_op2;
    result_d = result;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_d   = pick;
          last_d  = pick;
          op1_d   = op1_arr[pick];
          op2_d   = op2_arr[pick];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CW'(ADD_LATENCY - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          result_d = add_result;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    onehot_d = N_REQ'(1) << win_d;
    grant_d  = (state_d != ST_IDLE) ? onehot_d : '0;
    done_d   = (state_d == ST_DONE) ? onehot_d : '0;
    busy_d   = (state_d != ST_IDLE);
    enable_d = (state_d == ST_ISSUE);
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_served <= IW'(N_REQ - 1);
      win_q       <= '0;
      cnt_q       <= '0;
      add_op1     <= '0;
      add_op2     <= '0;
      result      <= '0;
      grant       <= '0;
      done        <= '0;
      busy        <= 1'b0;
      add_enable  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_served <= last_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      add_op1     <= op1_d;
      add_op2     <= op2_d;
      result      <= result_d;
      grant       <= grant_d;
      done        <= done_d;
      busy        <= busy_d;
      add_enable  <= enable_d;
    end
  end

endmodule
